// File: rtl/fft_r4_stage_sched_if.sv
// fft_r4_stage_sched_if: start/status, sample-memory, butterfly and twiddle signals of the radix-4 stage sequencer.
// cycle_cnt exists only when FFT_CYCLE_CNT_EN is defined.
interface fft_r4_stage_sched_if #(parameter int LOG4N = 3);
    localparam int AW = 2 * LOG4N;
    logic start, busy, done, rd_en, rd_bank, bf_ctrl_in, bf_ctrl_out, wr_en, err;
    logic [AW-1:0] rd_addr_a, rd_addr_b, rd_addr_c, rd_addr_d;
    logic [AW-1:0] wr_addr_a, wr_addr_b, wr_addr_c, wr_addr_d, tw_exp;
    logic [LOG4N-1:0] stage;
`ifdef FFT_CYCLE_CNT_EN
    logic [15:0] cycle_cnt;
`endif
    modport master(
        output start, bf_ctrl_out,
        input busy, done, rd_en, rd_addr_a, rd_addr_b, rd_addr_c, rd_addr_d, rd_bank, bf_ctrl_in,
        input wr_en, wr_addr_a, wr_addr_b, wr_addr_c, wr_addr_d, tw_exp, stage, err
`ifdef FFT_CYCLE_CNT_EN
        , cycle_cnt
`endif
    );
    modport slave(
        input start, bf_ctrl_out,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, rd_addr_c, rd_addr_d, rd_bank, bf_ctrl_in,
        output wr_en, wr_addr_a, wr_addr_b, wr_addr_c, wr_addr_d, tw_exp, stage, err
`ifdef FFT_CYCLE_CNT_EN
        , cycle_cnt
`endif
    );
endinterface

// File: rtl/fft_r4_stage_sched.sv
// fft_r4_stage_sched: sequences LOG4N radix-4 DIF stages over a ping-pong memory, aligning write-back to the butterfly.
// FFT_CYCLE_CNT_EN adds a saturating busy-cycle counter on cycle_cnt.
module fft_r4_stage_sched #(
    parameter int LOG4N  = 3,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 2
) (
    input logic clk,
    input logic rst_n,
    fft_r4_stage_sched_if.slave bus
);
    localparam int AW = 2 * LOG4N;
    localparam int BW = AW - 2;
    localparam int D  = RD_LAT + BF_LAT;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, NEXT, DONE} state_e;

    state_e state_q, state_d;
    logic [LOG4N-1:0] stage_q, stage_d;
    logic [BW-1:0] b_q, b_d;
    logic [AW-1:0] fly_q, fly_d;
    logic bank_q, bank_d, err_q, err_d;
    logic [D-1:0] vld_q;
    logic [AW-1:0] adr_q [D][4];
    logic [AW-1:0] tw_q [D];
    logic rd_en, accept;
    logic [AW-1:0] sh, stride, o, base, tw;
    logic [AW-1:0] adr [4];

    assign accept = state_q == IDLE && bus.start;
    assign rd_en  = state_q == RUN;

    // stride = 4^(LOG4N-1-stage): b splits into group (upper bits) and offset (lower bits)
    always_comb begin
        sh     = AW'(2 * (LOG4N - 1)) - AW'({stage_q, 1'b0});
        stride = AW'(1) << sh;
        o      = AW'(b_q) & (stride - AW'(1));
        base   = ((AW'(b_q) >> sh) << (sh + AW'(2))) | o;
        tw     = rd_en ? o << AW'({stage_q, 1'b0}) : '0;
        for (int k = 0; k < 4; k++) adr[k] = rd_en ? base | (AW'(k) << sh) : '0;
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        b_d     = b_q;
        bank_d  = bank_q;
        err_d   = err_q | (bus.bf_ctrl_out != vld_q[D-1]);
        fly_d   = (rd_en && !vld_q[D-1]) ? fly_q + AW'(1) :
                  (!rd_en && vld_q[D-1]) ? fly_q - AW'(1) : fly_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = RUN;
                stage_d = '0;
                b_d     = '0;
                bank_d  = 1'b0;
                err_d   = 1'b0;
            end
            RUN: begin
                b_d = b_q + BW'(1);
                if (b_q == '1) state_d = DRAIN;
            end
            DRAIN: if (fly_d == '0) state_d = (stage_q == LOG4N'(LOG4N - 1)) ? DONE : NEXT;
            NEXT: begin
                state_d = RUN;
                stage_d = stage_q + LOG4N'(1);
                bank_d  = !bank_q;
            end
            DONE: begin
                state_d = IDLE;
                bank_d  = !bank_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stage_q <= '0;
            b_q     <= '0;
            fly_q   <= '0;
            bank_q  <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < D; i++) begin
                tw_q[i] <= '0;
                for (int k = 0; k < 4; k++) adr_q[i][k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            b_q      <= b_d;
            fly_q    <= fly_d;
            bank_q   <= bank_d;
            err_q    <= err_d;
            vld_q    <= {vld_q[D-2:0], rd_en};
            adr_q[0] <= adr;
            tw_q[0]  <= tw;
            for (int i = 1; i < D; i++) begin
                adr_q[i] <= adr_q[i-1];
                tw_q[i]  <= tw_q[i-1];
            end
        end
    end

`ifdef FFT_CYCLE_CNT_EN
    logic [15:0] cyc_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_q <= '0;
        else if (accept) cyc_q <= '0;
        else if (state_q != IDLE && cyc_q != '1) cyc_q <= cyc_q + 16'd1;
    end
    assign bus.cycle_cnt = cyc_q;
`endif

    assign bus.busy       = state_q != IDLE;
    assign bus.done       = state_q == DONE;
    assign bus.rd_en      = rd_en;
    assign bus.rd_addr_a  = adr[0];
    assign bus.rd_addr_b  = adr[1];
    assign bus.rd_addr_c  = adr[2];
    assign bus.rd_addr_d  = adr[3];
    assign bus.rd_bank    = bank_q;
    assign bus.bf_ctrl_in = vld_q[RD_LAT-1];
    assign bus.wr_en      = vld_q[D-1];
    assign bus.wr_addr_a  = adr_q[D-1][0];
    assign bus.wr_addr_b  = adr_q[D-1][1];
    assign bus.wr_addr_c  = adr_q[D-1][2];
    assign bus.wr_addr_d  = adr_q[D-1][3];
    assign bus.tw_exp     = tw_q[D-1];
    assign bus.stage      = stage_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_fft_r4_stage_sched.sv
// tb_fft_r4_stage_sched: randomized scenarios against an arithmetic model of the stage schedule and DIF addressing.
// Covers the cycle_cnt output when FFT_CYCLE_CNT_EN is defined.
module tb_fft_r4_stage_sched;
    localparam int L = 3, N = 4 ** L, AW = 2 * L, Q = N / 4;
    localparam int RDL = 1, BFL = 2, D = RDL + BFL;
    localparam int P = Q + D + 1, T = L * P;

    logic clk = 1'b0, rst_n = 1'b0;
    logic bf_rand = 1'b0, bf_rval = 1'b0, fault = 1'b0, err_prev = 1'b0;
    logic [1:0] bf_pipe;
    int n_cmp = 0, n_err = 0;
    logic [4*AW-1:0] obs_rd [0:T+4];
    logic [AW-1:0] obs_tw [0:T+4];

    fft_r4_stage_sched_if #(.LOG4N(L)) bus();
    fft_r4_stage_sched #(.LOG4N(L), .RD_LAT(RDL), .BF_LAT(BFL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // ideal butterfly: ctrl_out is ctrl_in delayed by two cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bf_pipe <= '0;
        else bf_pipe <= {bf_pipe[0], bus.bf_ctrl_in};
    end
    assign bus.bf_ctrl_out = bf_rand ? bf_rval : (fault ? 1'b0 : bf_pipe[1]);

    function automatic int ref_addr(int s, int b, int k);
        int st = 4 ** (L - 1 - s);
        return (b / st) * 4 * st + b % st + k * st;
    endfunction

    function automatic int ref_tw(int s, int b);
        int st = 4 ** (L - 1 - s);
        return ((b % st) * (4 ** s)) % N;
    endfunction

    function automatic logic [79:0] all_out();
        logic [15:0] cc = '0;
`ifdef FFT_CYCLE_CNT_EN
        cc = bus.cycle_cnt;
`else
        cc = '0;
`endif
        return {cc, bus.busy, bus.done, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b, bus.rd_addr_c, bus.rd_addr_d,
                bus.rd_bank, bus.bf_ctrl_in, bus.wr_en, bus.wr_addr_a, bus.wr_addr_b, bus.wr_addr_c,
                bus.wr_addr_d, bus.tw_exp, bus.stage, bus.err};
    endfunction

    // one run from start at cycle 0; optional stray starts, a forced-0 ctrl_out cycle, or an abort cycle
    task automatic do_run(input string nm, input int s1, input int s2, input int flt, input int abrt);
        logic [9:0] ce, co;
        logic [4*AW-1:0] ae;
        logic [5*AW-1:0] we;
        int s, r, wr_cnt, dn_cnt;
        logic act;
        @(negedge clk);
        n_cmp++;
        if (bus.err !== err_prev) begin
            n_err++;
            $display("FAIL %s err_before_start got %0b exp %0b", nm, bus.err, err_prev);
        end
        bus.start = 1'b1;
        wr_cnt = 0;
        dn_cnt = 0;
        for (int n = 1; n <= T + 4; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            fault = 1'b0;
            act = n <= T;
            s = act ? (n - 1) / P : L - 1;
            r = (n - 1) % P;
            ce = {act, n == T, act && r < Q, act && r >= RDL && r < Q + RDL, act && r >= D && r < Q + D,
                  act ? 1'(s % 2) : 1'(L % 2), flt >= 0 && n > flt, 3'(s)};
            co = {bus.busy, bus.done, bus.rd_en, bus.bf_ctrl_in, bus.wr_en, bus.rd_bank, bus.err, bus.stage};
            n_cmp++;
            if (co !== ce) begin
                n_err++;
                $display("FAIL %s ctl cyc %0d got %h exp %h", nm, n, co, ce);
            end
            obs_rd[n] = {bus.rd_addr_a, bus.rd_addr_b, bus.rd_addr_c, bus.rd_addr_d};
            obs_tw[n] = bus.tw_exp;
            if (ce[7]) begin
                ae = {AW'(ref_addr(s, r, 0)), AW'(ref_addr(s, r, 1)), AW'(ref_addr(s, r, 2)), AW'(ref_addr(s, r, 3))};
                n_cmp++;
                if (obs_rd[n] !== ae) begin
                    n_err++;
                    $display("FAIL %s rd_addr cyc %0d got %h exp %h", nm, n, obs_rd[n], ae);
                end
            end
            if (ce[5]) begin
                we = {AW'(ref_addr(s, r - D, 0)), AW'(ref_addr(s, r - D, 1)), AW'(ref_addr(s, r - D, 2)),
                      AW'(ref_addr(s, r - D, 3)), AW'(ref_tw(s, r - D))};
                n_cmp++;
                if ({bus.wr_addr_a, bus.wr_addr_b, bus.wr_addr_c, bus.wr_addr_d, bus.tw_exp} !== we) begin
                    n_err++;
                    $display("FAIL %s wr_addr/tw cyc %0d got %h exp %h", nm, n,
                             {bus.wr_addr_a, bus.wr_addr_b, bus.wr_addr_c, bus.wr_addr_d, bus.tw_exp}, we);
                end
            end
            wr_cnt += int'(bus.wr_en);
            dn_cnt += int'(bus.done);
            if (n == abrt) begin
                rst_n = 1'b0;
                #1;
                n_cmp++;
                if (all_out() !== '0) begin
                    n_err++;
                    $display("FAIL %s abort_outputs cyc %0d got %h exp 0", nm, n, all_out());
                end
                err_prev = 1'b0;
                return;
            end
            fault = n == flt;
            bus.start = n == s1 || n == s2;
        end
        bus.start = 1'b0;
        fault = 1'b0;
        n_cmp++;
        if (wr_cnt != Q * L || dn_cnt != 1) begin
            n_err++;
            $display("FAIL %s pulses got wr=%0d done=%0d exp wr=%0d done=1", nm, wr_cnt, dn_cnt, Q * L);
        end
`ifdef FFT_CYCLE_CNT_EN
        n_cmp++;
        if (bus.cycle_cnt !== 16'(T)) begin
            n_err++;
            $display("FAIL %s cycle_cnt got %0d exp %0d", nm, bus.cycle_cnt, T);
        end
`endif
        err_prev = flt >= 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bf_rand = 1'b1;
        repeat (6) begin
            @(negedge clk);
            bus.start = 1'($urandom);
            bf_rval = 1'($urandom);
            #1;
            n_cmp++;
            if (all_out() !== '0) begin
                n_err++;
                $display("FAIL reset_outputs got %h exp 0", all_out());
            end
        end
        bus.start = 1'b0;
        bf_rand = 1'b0;
        rst_n = 1'b1;
        repeat (100) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.rd_en, bus.wr_en, bus.busy} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_idle got %b exp 000", {bus.rd_en, bus.wr_en, bus.busy});
            end
        end
    endtask

    task automatic test_full_run();
        repeat ($urandom_range(0, 4)) @(negedge clk);
        do_run("full", -1, -1, -1, -1);
        n_cmp++;
        if ({obs_rd[6], obs_tw[9]} !== {6'd5, 6'd21, 6'd37, 6'd53, 6'd5}) begin
            n_err++;
            $display("FAIL spot_s0b5 got %h", {obs_rd[6], obs_tw[9]});
        end
        n_cmp++;
        if ({obs_rd[27], obs_tw[30]} !== {6'd18, 6'd22, 6'd26, 6'd30, 6'd8}) begin
            n_err++;
            $display("FAIL spot_s1b6 got %h", {obs_rd[27], obs_tw[30]});
        end
        n_cmp++;
        if ({obs_rd[56], obs_tw[59]} !== {6'd60, 6'd61, 6'd62, 6'd63, 6'd0}) begin
            n_err++;
            $display("FAIL spot_s2b15 got %h", {obs_rd[56], obs_tw[59]});
        end
        n_cmp++;
        if ({bus.rd_bank, bus.busy, bus.err} !== 3'b100) begin
            n_err++;
            $display("FAIL final_bank got %b exp 100", {bus.rd_bank, bus.busy, bus.err});
        end
    endtask

    task automatic test_stray_start();
        do_run("stray", 10, T, -1, -1);
        do_run("stray_rnd", int'($urandom_range(1, T - 1)), int'($urandom_range(1, T)), -1, -1);
    endtask

    task automatic test_fault();
        do_run("fault", -1, -1, 7, -1);
        do_run("fault_rnd", -1, -1, int'($urandom_range(0, L - 1)) * P + int'($urandom_range(D, Q + D - 1)) + 1, -1);
        do_run("after_fault", -1, -1, -1, -1);
    endtask

    task automatic test_abort();
        for (int a = 0; a < 2; a++) begin
            do_run("abort", -1, -1, -1, a == 0 ? 30 : int'($urandom_range(2, T - 1)));
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (10) begin
                @(negedge clk);
                n_cmp++;
                if ({bus.rd_en, bus.wr_en, bus.busy} !== 3'b000) begin
                    n_err++;
                    $display("FAIL abort_idle got %b exp 000", {bus.rd_en, bus.wr_en, bus.busy});
                end
            end
            do_run("post_abort", -1, -1, -1, -1);
        end
    endtask

    task automatic test_back_to_back();
        do_run("b2b_0", -1, -1, -1, -1);
        do_run("b2b_1", int'($urandom_range(1, T)), -1, -1, -1);
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_full_run();
        test_stray_start();
        test_fault();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
